// File: rtl/immediate_encoder.sv
// ---------------------------------------------------------------------------
// immediate_encoder
//
// Purpose:
//   Two-stage valid/ready pipeline that merges a two's-complement immediate
//   into a RISC-V style instruction word. The first stage captures the
//   request. The second stage holds the encoded word. Non-immediate bits
//   come from 'base'.
//
// Ports:
//   clk        in   1   single clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   request valid
//   in_ready   out  1   request accepted when in_valid && in_ready
//   type_      in   3   immediate format code (`IMM_I/`IMM_S/`IMM_B/`IMM_U/`IMM_J)
//   imm        in   32  immediate value (U: upper bits already positioned)
//   base       in   32  instruction word supplying non-immediate fields
//   out_valid  out  1   result valid
//   out_ready  in   1   result consumed when out_valid && out_ready
//   out        out  32  encoded instruction word
//   out_err    out  1   immediate not representable in the selected format
//   err_count  out  16  saturating count of delivered results with out_err=1
//
// Configuration:
//   IMMEDIATE_ENCODER_CHECK_EN defined   -> range checking, out_err and
//                                           err_count are active.
//   IMMEDIATE_ENCODER_CHECK_EN undefined -> out_err and err_count are tied
//                                           to 0. Encoding and timing are
//                                           unchanged.
// ---------------------------------------------------------------------------

// Format codes normally come from immediate_decoder.h. These fallbacks keep
// the file self-contained when that header is not part of the build.
`ifndef IMM_I
`define IMM_I 3'd0
`endif
`ifndef IMM_S
`define IMM_S 3'd1
`endif
`ifndef IMM_B
`define IMM_B 3'd2
`endif
`ifndef IMM_U
`define IMM_U 3'd3
`endif
`ifndef IMM_J
`define IMM_J 3'd4
`endif

module immediate_encoder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  type_,
   input  logic [31:0] imm,
   input  logic [31:0] base,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out,
   output logic        out_err,
   output logic [15:0] err_count
);

   // Merge the immediate into the base word. Out-of-range immediates are
   // simply truncated. Unknown formats pass the base word through.
   function automatic logic [31:0] encode_word(input logic [2:0]  t,
                                               input logic [31:0] i,
                                               input logic [31:0] b);
      logic [31:0] w;
      w = b;
      case (t)
         `IMM_I: w = {i[11:0], b[19:0]};
         `IMM_S: w = {i[11:5], b[24:12], i[4:0], b[6:0]};
         `IMM_B: w = {i[12], i[10:5], b[24:12], i[4:1], i[11], b[6:0]};
         `IMM_U: w = {i[31:12], b[11:0]};
         `IMM_J: w = {i[20], i[10:1], i[11], i[19:12], b[11:0]};
         default: w = b;
      endcase
      return w;
   endfunction

   logic        s1_valid_q, s1_valid_d;
   logic [2:0]  s1_type_q,  s1_type_d;
   logic [31:0] s1_imm_q,   s1_imm_d;
   logic [31:0] s1_base_q,  s1_base_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_q,       out_d;
   logic        s2_ready;

   // S2 can take a new word when it is empty or its word leaves this cycle.
   // S1 can take a request when it is empty or it moves into S2.
   assign s2_ready = !out_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s2_ready;

   // Next-state for both stages. Data registers only load when a valid
   // item moves in. This keeps out stable while the consumer stalls.
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_type_d   = s1_type_q;
      s1_imm_d    = s1_imm_q;
      s1_base_d   = s1_base_q;
      out_valid_d = out_valid_q;
      out_d       = out_q;
      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_type_d = type_;
            s1_imm_d  = imm;
            s1_base_d = base;
         end
      end
      if (s2_ready) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_d = encode_word(s1_type_q, s1_imm_q, s1_base_q);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_type_q   <= 3'd0;
         s1_imm_q    <= 32'd0;
         s1_base_q   <= 32'd0;
         out_valid_q <= 1'b0;
         out_q       <= 32'd0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_type_q   <= s1_type_d;
         s1_imm_q    <= s1_imm_d;
         s1_base_q   <= s1_base_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out       = out_q;

`ifdef IMMEDIATE_ENCODER_CHECK_EN
   // Returns 1 when the immediate cannot be represented in the format.
   // Sign-extension bits must all agree. B/J offsets must be even.
   // U immediates must have a clear low 12 bits.
   function automatic logic range_error(input logic [2:0]  t,
                                        input logic [31:0] i);
      logic e;
      e = 1'b1;
      case (t)
         `IMM_I, `IMM_S: e = !((i[31:11] == {21{1'b0}}) || (i[31:11] == {21{1'b1}}));
         `IMM_B: e = !((i[31:12] == {20{1'b0}}) || (i[31:12] == {20{1'b1}})) || i[0];
         `IMM_U: e = (i[11:0] != 12'd0);
         `IMM_J: e = !((i[31:20] == {12{1'b0}}) || (i[31:20] == {12{1'b1}})) || i[0];
         default: e = 1'b1;
      endcase
      return e;
   endfunction

   logic        s1_err_q,    s1_err_d;
   logic        out_err_q,   out_err_d;
   logic [15:0] err_count_q, err_count_d;

   // The error flag follows its request through the pipeline. The counter
   // only moves when an erroring result is actually consumed. It sticks at
   // all-ones.
   always_comb begin
      s1_err_d    = s1_err_q;
      out_err_d   = out_err_q;
      err_count_d = err_count_q;
      if (in_ready && in_valid) begin
         s1_err_d = range_error(type_, imm);
      end
      if (s2_ready && s1_valid_q) begin
         out_err_d = s1_err_q;
      end
      if (out_valid_q && out_ready && out_err_q && (err_count_q != 16'hFFFF)) begin
         err_count_d = err_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_err_q    <= 1'b0;
         out_err_q   <= 1'b0;
         err_count_q <= 16'd0;
      end else begin
         s1_err_q    <= s1_err_d;
         out_err_q   <= out_err_d;
         err_count_q <= err_count_d;
      end
   end

   assign out_err   = out_err_q;
   assign err_count = err_count_q;
`else
   assign out_err   = 1'b0;
   assign err_count = 16'd0;
`endif

endmodule

// File: tb/tb_immediate_encoder.sv
// ---------------------------------------------------------------------------
// tb_immediate_encoder
//
// Purpose:
//   Directed self-checking bench for immediate_encoder. The bench drives
//   single transactions through the pipeline, then back-to-back requests
//   under backpressure. It also applies reset while requests are in flight
//   and runs an error-count saturation burst.
//
//   Expected error results follow IMMEDIATE_ENCODER_CHECK_EN in the same
//   way as the design.
// ---------------------------------------------------------------------------

`ifndef IMM_I
`define IMM_I 3'd0
`endif
`ifndef IMM_S
`define IMM_S 3'd1
`endif
`ifndef IMM_B
`define IMM_B 3'd2
`endif
`ifndef IMM_U
`define IMM_U 3'd3
`endif
`ifndef IMM_J
`define IMM_J 3'd4
`endif

module tb_immediate_encoder;

`ifdef IMMEDIATE_ENCODER_CHECK_EN
   localparam logic        CHK      = 1'b1;
   localparam int          SAT_REQS = 65537;
   localparam logic [15:0] SAT_EXP  = 16'hFFFF;
`else
   localparam logic        CHK      = 1'b0;
   localparam int          SAT_REQS = 10;
   localparam logic [15:0] SAT_EXP  = 16'h0000;
`endif

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  type_;
   logic [31:0] imm;
   logic [31:0] base;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out;
   logic        out_err;
   logic [15:0] err_count;

   int compared   = 0;
   int mismatched = 0;

   immediate_encoder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .type_     (type_),
      .imm       (imm),
      .base      (base),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_err   (out_err),
      .err_count (err_count)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // A hung pipeline must not stall the run.
   initial begin
      #5000000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Backpressure vectors (I format, all in range).
   logic [31:0] bpImm  [4] = '{32'h00000001, 32'h00000002, 32'h00000003, 32'hFFFFFFFC};
   logic [31:0] bpBase [4] = '{32'h00000093, 32'h00000113, 32'h00000193, 32'h00000213};
   logic [31:0] bpExp  [4] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'hFFC00213};

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkVal(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Present one request and wait (bounded) until it is accepted.
   task automatic applyStimulus(input logic [2:0] t, input logic [31:0] i,
                                input logic [31:0] b);
      type_    = t;
      imm      = i;
      base     = b;
      in_valid = 1'b1;
      #1;
      for (int k = 0; k < 20 && !in_ready; k++) tick();
      checkVal("in_ready_wait", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   // Called right after acceptance with out_ready=1. The result shows one
   // edge later and is consumed on the following edge.
   task automatic checkOutput(input string tag, input logic [31:0] expOut,
                              input logic expErr);
      tick();
      checkVal({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      checkVal({tag, "_out"}, out, expOut);
      checkVal({tag, "_err"}, {31'd0, out_err}, {31'd0, expErr});
      tick();
      checkVal({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      int  ri;
      int  ro;
      bit  hs;
      bit  stale;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      type_     = 3'd0;
      imm       = 32'd0;
      base      = 32'd0;

      // Reset state.
      tick();
      tick();
      checkVal("rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkVal("rst_out", out, 32'd0);
      checkVal("rst_out_err", {31'd0, out_err}, 32'd0);
      checkVal("rst_err_count", {16'd0, err_count}, 32'd0);
      rst_n = 1'b1;
      tick();
      checkVal("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Directed single transactions with the consumer always ready.
      out_ready = 1'b1;
      applyStimulus(`IMM_I, 32'hFFFFFFFF, 32'h00000013);
      checkVal("i_latency_not_1", {31'd0, out_valid}, 32'd0);
      checkOutput("i_neg1", 32'hFFF00013, 1'b0);

      applyStimulus(`IMM_S, 32'hFFFFFFF5, 32'h00002023);
      checkOutput("s_neg11", 32'hFE002AA3, 1'b0);

      applyStimulus(`IMM_B, 32'h00000800, 32'h00000063);
      checkOutput("b_2048", 32'h000000E3, 1'b0);

      applyStimulus(`IMM_B, 32'h00000001, 32'h00000063);
      checkOutput("b_odd", 32'h00000063, CHK);
      checkVal("b_odd_count", {16'd0, err_count}, CHK ? 32'd1 : 32'd0);

      applyStimulus(`IMM_U, 32'h12345000, 32'h00000037);
      checkOutput("u_ok", 32'h12345037, 1'b0);

      applyStimulus(`IMM_U, 32'h12345001, 32'h00000037);
      checkOutput("u_low_bits", 32'h12345037, CHK);

      applyStimulus(`IMM_J, 32'h00000800, 32'h0000006F);
      checkOutput("j_2048", 32'h0010006F, 1'b0);

      applyStimulus(`IMM_J, 32'hFFFFFFFE, 32'h0000006F);
      checkOutput("j_neg2", 32'hFFFFF06F, 1'b0);

      applyStimulus(`IMM_I, 32'h00000800, 32'h00000013);
      checkOutput("i_overflow", 32'h80000013, CHK);

      applyStimulus(3'd7, 32'h12345678, 32'hDEADBEEF);
      checkOutput("undef_type", 32'hDEADBEEF, CHK);
      checkVal("err_count_4", {16'd0, err_count}, CHK ? 32'd4 : 32'd0);

      // Backpressure: two requests fill the pipe, then in_ready must drop.
      out_ready = 1'b0;
      applyStimulus(`IMM_I, bpImm[0], bpBase[0]);
      applyStimulus(`IMM_I, bpImm[1], bpBase[1]);
      type_    = `IMM_I;
      imm      = bpImm[2];
      base     = bpBase[2];
      in_valid = 1'b1;
      #1;
      checkVal("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
      for (int c = 0; c < 3; c++) begin
         checkVal($sformatf("bp_stall_valid%0d", c), {31'd0, out_valid}, 32'd1);
         checkVal($sformatf("bp_stall_out%0d", c), out, bpExp[0]);
         tick();
      end

      // Release the consumer and stream the remaining requests.
      out_ready = 1'b1;
      ri = 2;
      ro = 0;
      for (int c = 0; c < 40 && ro < 4; c++) begin
         in_valid = (ri < 4);
         if (ri < 4) begin
            imm  = bpImm[ri];
            base = bpBase[ri];
         end
         #1;
         if (out_valid && out_ready) begin
            checkVal($sformatf("bp_out%0d", ro), out, bpExp[ro]);
            ro++;
         end
         hs = in_valid && in_ready;
         tick();
         if (hs) ri++;
      end
      in_valid = 1'b0;
      checkVal("bp_all_accepted", ri, 32'd4);
      checkVal("bp_all_emitted", ro, 32'd4);
      tick();
      tick();
      checkVal("bp_no_duplicate", {31'd0, out_valid}, 32'd0);

      // Reset with two erroneous requests in flight.
      out_ready = 1'b0;
      applyStimulus(`IMM_B, 32'h00000001, 32'h00000063);
      applyStimulus(3'd7, 32'h0, 32'h11111111);
      #2;
      rst_n = 1'b0;
      #1;
      checkVal("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      checkVal("mid_rst_out", out, 32'd0);
      checkVal("mid_rst_out_err", {31'd0, out_err}, 32'd0);
      checkVal("mid_rst_err_count", {16'd0, err_count}, 32'd0);
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      stale     = 1'b0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (out_valid) stale = 1'b1;
      end
      checkVal("mid_rst_no_stale", {31'd0, stale}, 32'd0);
      checkVal("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      checkVal("mid_rst_count_zero", {16'd0, err_count}, 32'd0);

      // Full-rate burst of erroneous requests to exercise counter saturation.
      type_    = 3'd7;
      imm      = 32'd0;
      base     = 32'h00000013;
      in_valid = 1'b1;
      for (int n = 0; n < SAT_REQS; n++) tick();
      in_valid = 1'b0;
      for (int n = 0; n < 4; n++) tick();
      checkVal("sat_err_count", {16'd0, err_count}, {16'd0, SAT_EXP});
      checkVal("sat_out", out, 32'h00000013);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/immediate_encoder.md
IMMEDIATE_ENCODER -- requirements
Module: immediate_encoder

Interface
REQ-001 Parameters: none. Type codes SHALL be the `IMM_I/`IMM_S/`IMM_B/`IMM_U/`IMM_J macros from immediate_decoder.h.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  request accepted when in_valid && in_ready.
REQ-006 type_  input  3  immediate format code.
REQ-007 imm  input  32  immediate value, two's complement (U: upper bits already positioned).
REQ-008 base  input  32  instruction word supplying non-immediate fields.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  result consumed when out_valid && out_ready.
REQ-011 out  output  32  encoded instruction word.
REQ-012 out_err  output  1  immediate not representable in the selected format.
REQ-013 err_count  output  16  saturating count of results delivered with out_err=1.

Function
REQ-014 Two-stage pipeline: S1 registers request and computes range check; S2 registers merged word; latency 2 cycles from acceptance to out_valid; throughput 1 per cycle.
REQ-015 Stage advances when empty or its downstream accepts; in_ready = !S1.valid || S1 advances; no data lost or duplicated under any out_ready pattern.
REQ-016 out, out_err SHALL hold stable while out_valid && !out_ready.
REQ-017 I: out[31:20]=imm[11:0], out[19:0]=base[19:0].
REQ-018 S: out[31:25]=imm[11:5], out[11:7]=imm[4:0], other bits from base.
REQ-019 B: out[31]=imm[12], out[30:25]=imm[10:5], out[11:8]=imm[4:1], out[7]=imm[11], other bits from base.
REQ-020 U: out[31:12]=imm[31:12], out[11:0]=base[11:0].
REQ-021 J: out[31]=imm[20], out[30:21]=imm[10:1], out[20]=imm[11], out[19:12]=imm[19:12], out[11:0]=base[11:0].
REQ-022 Range rules: I/S imm[31:11] all equal; B imm[31:12] all equal and imm[0]=0; U imm[11:0]=0; J imm[31:20] all equal and imm[0]=0; violation -> out_err=1.
REQ-023 Out-of-range immediates still encoded per REQ-017..021 (truncated); out_err flags them.
REQ-024 Undefined type_ -> out=base, out_err=1.
REQ-025 err_count increments by 1 on each accepted result with out_err=1; saturates at 0xFFFF.

Reset
REQ-026 rst_n low SHALL immediately clear both stage valids, out_valid=0, out=0, out_err=0, err_count=0.
REQ-027 in_ready SHALL be 1 from the first edge after reset deassertion; in-flight requests at reset SHALL be discarded, never emitted.

Configuration
REQ-028 Macro IMMEDIATE_ENCODER_CHECK_EN defined: REQ-022, REQ-024 error flagging and REQ-025 counter active.
REQ-029 Macro undefined: no range check logic; out_err tied 0, err_count tied 0; undefined type_ still yields out=base; encoding and timing unchanged.

Verification
REQ-030 I: type_=IMM_I, imm=0xFFFFFFFF, base=0x00000013 -> out=0xFFF00013, out_err=0, out_valid 2 cycles after acceptance.
REQ-031 B: imm=0x00000800, base=0x00000063 -> out=0x000000E3, out_err=0; imm=0x00000001 -> out_err=1, err_count=1 (CHECK_EN).
REQ-032 U: imm=0x12345000, base=0x00000037 -> out=0x12345037; imm=0x12345001 -> out_err=1 (CHECK_EN), 0 without macro.
REQ-033 Backpressure: 4 back-to-back requests, out_ready=0 for 3 cycles -> in_ready falls after 2 accepted, out stable, all 4 emitted in order, none lost.
REQ-034 Reset mid-operation: rst_n low with 2 in flight -> out_valid=0 at once; after release no stale result emitted, err_count=0.
REQ-035 Saturation: 65537 erroneous requests -> err_count=0xFFFF.
